// File: rtl/led7_pkg.sv
// Shared constants for the 4-digit seven-segment scanner.
package led7_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns; element n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
    import led7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Plain table lookup; the glyphs live in the package so all users agree.
    always_comb begin
        seg = SEG_TABLE[nib];
    end

endmodule

// File: rtl/led7_scan.sv
// Multiplexed 4-digit seven-segment driver with per-frame snapshot,
// PWM brightness, leading-zero blanking and registered pin outputs.
module led7_scan
    import led7_pkg::*;
#(
    parameter int PRESCALE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  bright,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic [3:0]  an,
    output logic        frame
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    dp_sh_q, dp_sh_d;
    logic [6:0]    seg_q, seg_d;
    logic          seg_dp_q, seg_dp_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          snap;
    logic [3:0]    phase;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic          blanked;
    logic          lit;

    hex7seg u_dec (
        .nib (nib),
        .seg (glyph)
    );

    // Slot timing: prescaler, digit index and the sub-slot PWM phase.
    always_comb begin
        tick  = (pcnt_q == PW'(PRESCALE - 1));
        snap  = tick && (dig_q == 2'd3);
        phase = pcnt_q[PW-1 -: 4];
        nib   = shadow_q[{dig_q, 2'b00} +: 4];
    end

    // lead_zero[d] is set when shadow nibbles d..3 are all zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = (shadow_q[15:12] == 4'h0);
        for (int d = NUM_DIGITS - 2; d >= 0; d--) begin
            lead_zero[d] = lead_zero[d+1] && (shadow_q[4*d +: 4] == 4'h0);
        end
        blanked = blank_lz && (dig_q != 2'd0) && lead_zero[dig_q];
        // Phase 0 stays dark so the previous digit's segments never ghost.
        lit     = (phase != 4'd0) && (phase <= bright) && !blanked;
    end

    // Next-state: counters advance, shadows reload only at the frame boundary.
    always_comb begin
        pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
        dig_d    = tick ? dig_q + 2'd1 : dig_q;
        shadow_d = snap ? value : shadow_q;
        dp_sh_d  = snap ? dp : dp_sh_q;
        frame_d  = snap;
        seg_d    = SEG_BLANK;
        seg_dp_d = 1'b1;
        an_d     = 4'hF;
        if (lit) begin
            seg_d    = glyph;
            seg_dp_d = ~dp_sh_q[dig_q];
            an_d     = ~(4'b0001 << dig_q);
        end
    end

    // State and output registers; reset wins immediately, no slot completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q   <= '0;
            dig_q    <= 2'd0;
            shadow_q <= 16'h0000;
            dp_sh_q  <= 4'h0;
            seg_q    <= SEG_BLANK;
            seg_dp_q <= 1'b1;
            an_q     <= 4'hF;
            frame_q  <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            dp_sh_q  <= dp_sh_d;
            seg_q    <= seg_d;
            seg_dp_q <= seg_dp_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign seg    = seg_q;
    assign seg_dp = seg_dp_q;
    assign an     = an_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_led7_scan.sv
// Bench for led7_scan at PRESCALE=64: cycle-by-cycle reference model plus
// directed duty/timing checks and a randomized soak.
module tb_led7_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  bright;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame;

    led7_scan #(.PRESCALE(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .dp       (dp),
        .bright   (bright),
        .blank_lz (blank_lz),
        .seg      (seg),
        .seg_dp   (seg_dp),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          vectors = 0;
    int          errors  = 0;
    // Reference state: cycles since reset release plus the displayed snapshot.
    int          t = 0;
    logic [15:0] sh = 16'h0;
    logic [3:0]  dps = 4'h0;
    int          cnt_low = 0;
    int          cnt_hi  = 0;
    int          first_frame = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pins produced from a given slot position and snapshot.
    function automatic logic [12:0] model_out(input int p, input int d, input logic [15:0] s,
                                              input logic [3:0] ds, input logic [3:0] br,
                                              input logic bl, input logic fr);
        int   ph;
        int   upper;
        logic lit;
        ph    = p / 4;
        upper = int'(s) >> (4 * d);
        lit   = (ph > 0) && (ph <= int'(br)) && !(bl && d > 0 && upper == 0);
        if (lit) return {HEX[upper % 16], ~ds[d], ~(4'b0001 << d), fr};
        return {7'h7F, 1'b1, 4'hF, fr};
    endfunction

    task automatic step();
        logic [12:0] exp;
        int   p, d;
        logic fr;
        @(posedge clk);
        if (reset) begin
            exp = {7'h7F, 1'b1, 4'hF, 1'b0};
            t = 0; sh = 16'h0; dps = 4'h0;
        end else begin
            p  = t % 64;
            d  = (t / 64) % 4;
            fr = (p == 63) && (d == 3);
            exp = model_out(p, d, sh, dps, bright, blank_lz, fr);
            if (fr) begin sh = value; dps = dp; end
            t++;
        end
        #1;
        chk(reset ? "reset_pins" : "pins", 32'({seg, seg_dp, an, frame}), 32'(exp));
        if (an != 4'hF) cnt_low++;
        if (an[3:1] != 3'b111) cnt_hi++;
        if (!reset && frame && first_frame < 0) first_frame = t;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; value = 16'h1234; dp = 4'h0; bright = 4'd15; blank_lz = 1'b0;

        // Reset held three cycles
        run(3);
        reset = 1'b0;

        // Display 1234 at full brightness; first frame pulse after 256 cycles
        run(256);
        chk("first_frame_cycle", 32'(first_frame), 32'd256);
        cnt_low = 0;
        run(256);
        chk("duty_bright15", 32'(cnt_low), 32'd240);

        // Mid-frame change must not appear until the next snapshot
        run(100);
        value = 16'hABCD; dp = 4'b0101;
        run(156 + 512);

        // Brightness 4 then 0
        bright = 4'd4; run(1); cnt_low = 0; run(256);
        chk("duty_bright4", 32'(cnt_low), 32'd64);
        bright = 4'd0; run(1); cnt_low = 0; run(256);
        chk("duty_bright0", 32'(cnt_low), 32'd0);

        // Leading-zero blanking
        bright = 4'd15; blank_lz = 1'b1; value = 16'h0005; dp = 4'hF;
        run(256); cnt_hi = 0; cnt_low = 0; run(256);
        chk("blank_upper_dark", 32'(cnt_hi), 32'd0);
        chk("blank_digit0_duty", 32'(cnt_low), 32'd60);
        value = 16'h0000; run(512);
        blank_lz = 1'b0; value = 16'h0005; run(256); cnt_hi = 0; run(256);
        chk("noblank_upper_lit", 32'(cnt_hi), 32'd180);

        // Reset mid-operation at pcnt=30, dig=2
        value = 16'h9876;
        for (int i = 0; i < 300 && (t % 256) != 158; i++) step();
        chk("reach_mid_slot", 32'(t % 256), 32'd158);
        reset = 1'b1; run(1);
        reset = 1'b0; run(300);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49) == 0) begin value = 16'($urandom); dp = 4'($urandom); end
            if ($urandom_range(199) == 0) begin bright = 4'($urandom); blank_lz = 1'($urandom); end
            reset = ($urandom_range(999) == 0);
            step();
        end
        reset = 1'b0; run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
